// File: rtl/rgb_overlay_pal.sv
// rtl/rgb_overlay_pal.sv - VGA pixel colouriser with writable 8-entry palette and alarm blink
module rgb_overlay_pal #(
  parameter int          COLOR_BITS = 4,
  parameter int          FRAME_X0   = 48,
  parameter int          FRAME_X1   = 688,
  parameter int          FRAME_Y0   = 35,
  parameter int          FRAME_Y1   = 514,
  parameter int          FRAME_T    = 4,
  parameter int          SEP1_Y     = 240,
  parameter int          SEP2_Y     = 330,
  parameter int          LINE_T     = 2,
  parameter int          BLINK_HALF = 50000000,
  parameter logic [7:0]  ALARM_PORT = 8'h00,
  parameter logic [7:0]  PAL_BASE   = 8'h20
) (
  input  logic                  reloj,
  input  logic                  resetM,
  input  logic [7:0]            port_id,
  input  logic [7:0]            out_port,
  input  logic                  write_strobe,
  input  logic [9:0]            Qh,
  input  logic [9:0]            Qv,
  input  logic                  H_ON,
  input  logic                  V_ON,
  input  logic                  bit_fuente,
  input  logic                  cursor_en,
  input  logic [8:0]            cam_co,
  output logic [COLOR_BITS-1:0] R,
  output logic [COLOR_BITS-1:0] G,
  output logic [COLOR_BITS-1:0] B,
  output logic                  alarma_fase
);

  localparam int CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

  // Inner edges of the outer frame band.
  localparam int FX_IN0 = FRAME_X0 + FRAME_T;
  localparam int FX_IN1 = FRAME_X1 - FRAME_T;
  localparam int FY_IN0 = FRAME_Y0 + FRAME_T;
  localparam int FY_IN1 = FRAME_Y1 - FRAME_T;
  localparam int SEP1_END = SEP1_Y + LINE_T;
  localparam int SEP2_END = SEP2_Y + LINE_T;

  // Default colours as 12-bit 4:4:4 RGB nibbles.
  function automatic logic [11:0] def_rgb(input int i);
    logic [11:0] v;
    case (i)
      0:       v = 12'h001;
      1:       v = 12'hCFC;
      2:       v = 12'h066;
      3:       v = 12'h063;
      4:       v = 12'h007;
      5:       v = 12'hFFF;
      6:       v = 12'hFFF;
      default: v = 12'h007;
    endcase
    return v;
  endfunction

  // Left-align a 4-bit nibble into COLOR_BITS, zero-filling or truncating LSBs.
  function automatic logic [COLOR_BITS-1:0] expand(input logic [3:0] nib);
    logic [COLOR_BITS-1:0] r;
    int src;
    r = '0;
    for (int b = 0; b < COLOR_BITS; b++) begin
      src = b + 4 - COLOR_BITS;
      if (src >= 0) r[b] = nib[src[1:0]];
    end
    return r;
  endfunction

  // Channel c (0=R, 1=G, 2=B) of default entry i.
  function automatic logic [COLOR_BITS-1:0] def_chan(input int i, input int c);
    logic [11:0] rgb;
    logic [3:0]  nib;
    rgb = def_rgb(i);
    case (c)
      0:       nib = rgb[11:8];
      1:       nib = rgb[7:4];
      default: nib = rgb[3:0];
    endcase
    return expand(nib);
  endfunction

  logic [COLOR_BITS-1:0] pal_r [8];
  logic [COLOR_BITS-1:0] pal_g [8];
  logic [COLOR_BITS-1:0] pal_b [8];

  logic             alarm;
  logic             phase;
  logic [CNT_W-1:0] blink_cnt;

  logic en_q, border_q, font_q, hl_q, alm_q, ph_q;

  // Port decode: offset wraps, so addresses below PAL_BASE land far outside 0..31.
  logic [7:0]            pal_off;
  logic                  pal_hit;
  logic [2:0]            pal_idx;
  logic [1:0]            pal_chan;
  logic [COLOR_BITS-1:0] pal_data;
  logic                  unused_bits;

  assign pal_off     = port_id - PAL_BASE;
  assign pal_hit     = write_strobe && (pal_off < 8'd32) && (pal_off[1:0] != 2'd3);
  assign pal_idx     = pal_off[4:2];
  assign pal_chan    = pal_off[1:0];
  assign pal_data    = out_port[COLOR_BITS-1:0];
  assign unused_bits = ^out_port;

  // Alarm enable register written from the port bus.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      alarm <= 1'b0;
    end else if (write_strobe && port_id == ALARM_PORT) begin
      alarm <= out_port[0];
    end
  end

  // Palette storage; reset restores the built-in colour set.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      for (int i = 0; i < 8; i++) begin
        pal_r[i] <= def_chan(i, 0);
        pal_g[i] <= def_chan(i, 1);
        pal_b[i] <= def_chan(i, 2);
      end
    end else if (pal_hit) begin
      case (pal_chan)
        2'd0:    pal_r[pal_idx] <= pal_data;
        2'd1:    pal_g[pal_idx] <= pal_data;
        default: pal_b[pal_idx] <= pal_data;
      endcase
    end
  end

  // Blink generator: free-runs only while the alarm is enabled.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (!alarm) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign alarma_fase = phase;

  // Geometry classification of the current beam position.
  int   qh_i, qv_i;
  logic en_c, in_x, in_y, frame_c, sep_c;

  assign qh_i = int'(Qh);
  assign qv_i = int'(Qv);
  assign en_c = H_ON & V_ON;
  assign in_x = (qh_i >= FRAME_X0) && (qh_i < FRAME_X1);
  assign in_y = (qv_i >= FRAME_Y0) && (qv_i < FRAME_Y1);
  assign frame_c = en_c && in_x && in_y &&
                   ((qh_i < FX_IN0) || (qh_i >= FX_IN1) ||
                    (qv_i < FY_IN0) || (qv_i >= FY_IN1));
  assign sep_c   = en_c && in_x &&
                   (((qv_i >= SEP1_Y) && (qv_i < SEP1_END)) ||
                    ((qv_i >= SEP2_Y) && (qv_i < SEP2_END)));

  // Stage 1: register pixel flags together with the alarm state they belong to.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      en_q     <= 1'b0;
      border_q <= 1'b0;
      font_q   <= 1'b0;
      hl_q     <= 1'b0;
      alm_q    <= 1'b0;
      ph_q     <= 1'b0;
    end else begin
      en_q     <= en_c;
      border_q <= frame_c | sep_c;
      font_q   <= bit_fuente;
      hl_q     <= cursor_en & (|cam_co);
      alm_q    <= alarm;
      ph_q     <= phase;
    end
  end

  // Palette index selection; cursor highlight has no effect during alarm.
  logic [2:0] idx;
  always_comb begin
    idx = 3'd0;
    if (!alm_q) begin
      if (border_q)    idx = 3'd2;
      else if (font_q) idx = 3'd1;
      else if (hl_q)   idx = 3'd3;
      else             idx = 3'd0;
    end else begin
      if (border_q)    idx = 3'd7;
      else if (font_q) idx = 3'd6;
      else             idx = ph_q ? 3'd5 : 3'd4;
    end
  end

  // Stage 2: palette lookup into the output registers, blanked outside active video.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      R <= '0;
      G <= '0;
      B <= '0;
    end else if (!en_q) begin
      R <= '0;
      G <= '0;
      B <= '0;
    end else begin
      R <= pal_r[idx];
      G <= pal_g[idx];
      B <= pal_b[idx];
    end
  end

endmodule

// File: doc/rgb_overlay_pal.md
Name: rgb_overlay_pal

Overview:
- Parametrised successor to the VGA pixel colouriser. Converts per-pixel context into registered R/G/B: beam position, display-enable, font bit, cursor cell and alarm state.
- Replaces hard-coded colours with an 8-entry palette that the PicoBlaze writes through the port bus.
- Geometry (frame, separators) and colour depth are parameters.
- Generates the alarm blink internally with a programmable half-period.
- Sits between the VGA sync counter / character ROM and the DAC pins.

Parameters:
- COLOR_BITS, 4, bits per channel (1..8); outputs R/G/B are COLOR_BITS wide.
- FRAME_X0, 48, first frame column. FRAME_X1, 688, column one past the frame's right edge.
- FRAME_Y0, 35, first frame row. FRAME_Y1, 514, row one past the frame's bottom edge.
- FRAME_T, 4, outer frame thickness in pixels.
- SEP1_Y, 240, first horizontal separator row. SEP2_Y, 330, second separator row.
- LINE_T, 2, separator thickness.
- BLINK_HALF, 50000000, alarm half-period in clocks. Must be >= 1.
- ALARM_PORT, 8'h00, port_id of the alarm enable register.
- PAL_BASE, 8'h20, base port_id of the palette; occupies PAL_BASE..PAL_BASE+31.

Ports:
- reloj  in  1  system/pixel clock; all logic on rising edge.
- resetM  in  1  asynchronous, active-low reset.
- port_id  in  8  PicoBlaze port address.
- out_port  in  8  PicoBlaze write data.
- write_strobe  in  1  one-cycle write qualifier.
- Qh  in  10  horizontal pixel counter.
- Qv  in  10  vertical pixel counter.
- H_ON  in  1  horizontal active video.
- V_ON  in  1  vertical active video.
- bit_fuente  in  1  font pixel, aligned with Qh/Qv.
- cursor_en  in  1  cursor highlight mode active.
- cam_co  in  9  one-hot selected cell; highlight when any bit is set.
- R, G, B  out  COLOR_BITS each  registered colour outputs.
- alarma_fase  out  1  current blink phase, for LEDs/debug.

Behaviour:
- Reset (resetM=0, async):
  - R/G/B=0, alarma_fase=0, alarm register=0, blink counter=0, pipeline flags=0.
  - Palette loads defaults, 4-bit RGB left-aligned into COLOR_BITS with zeroed LSBs (truncated if COLOR_BITS<4): 0:001 bg, 1:CFC font, 2:066 border, 3:063 cursor, 4:007 alarm bg ph0, 5:FFF alarm bg ph1, 6:FFF alarm font, 7:007 alarm border.
- Port writes (only when write_strobe=1):
  - port_id==ALARM_PORT: alarm <= out_port[0].
  - port_id==PAL_BASE+4*i+c, with i 0..7 and c 0=R, 1=G, 2=B: channel c of entry i <= out_port[COLOR_BITS-1:0].
  - c==3 and other addresses: ignored.
- Blink counter:
  - While alarm=0: counter=0, phase=0.
  - While alarm=1: counter increments each clock. Phase toggles and counter returns to 0 when counter==BLINK_HALF-1. First toggle occurs BLINK_HALF clocks after alarm is set.
  - Clearing alarm zeroes counter and phase the next clock.
  - alarma_fase = phase register.
- Stage 1 (registered flags from Qh/Qv):
  - en = H_ON&V_ON.
  - frame = en & inside [X0,X1)x[Y0,Y1) & (Qh<X0+T | Qh>=X1-T | Qv<Y0+T | Qv>=Y1-T).
  - sep = en & X0<=Qh<X1 & (SEP1_Y<=Qv<SEP1_Y+LINE_T | SEP2_Y<=Qv<SEP2_Y+LINE_T).
  - border = frame|sep.
  - Also registered: font=bit_fuente, hl=cursor_en&|cam_co, alm=alarm, ph=phase.
- Stage 2 (palette index; priority top-down):
  - !en -> output 0.
  - alm=0: border->2, font->1, hl->3, else 0.
  - alm=1: border->7, font->6, else ph?5:4. Cursor highlight is ignored during alarm.
  - R/G/B <= palette[index].
- Latency: 2 clocks from Qh/Qv/H_ON/V_ON/bit_fuente to R/G/B.
- Palette write and stage-2 read of the same entry in the same clock: stage 2 uses the old value; the new value is used from the next clock.
- Reset asserted mid-frame: outputs go to 0 immediately. After release, the first valid pixel appears 2 clocks later.

Test Plan:
- Reset, then H_ON=V_ON=1, Qh=100, Qv=100, bit_fuente=0, cursor_en=0 -> 2 clocks later RGB=0,0,1. Set bit_fuente=1 -> RGB=C,F,C.
- Qh=48, Qv=100 (frame) -> RGB=0,6,6. Qh=52, Qv=240 (separator) -> 0,6,6. Qh=52, Qv=242 -> background 0,0,1. Qh=688 -> background 0,0,1 (outside frame). H_ON=0 at Qh=48 -> 0,0,0.
- cursor_en=1, cam_co=9'b000010000, bit_fuente=0 -> 0,6,3. Same with bit_fuente=1 -> C,F,C (font wins).
- BLINK_HALF=4. Write out_port=1 to port 00 with strobe -> alarma_fase rises 4 clocks later, falls after 4 more. Background alternates 0,0,7 / F,F,F. Border 0,0,7. Write 0 -> phase 0 and normal colours next frame.
- Write port 0x21=0xA, 0x22=0x5 (entry 0 G,B) -> background 0,A,5. Writes to 0x23 and 0x40 change nothing. Pulse resetM low asynchronously mid-write -> outputs 0 instantly and palette defaults restored.
